// File: rtl/fp_multiplier_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control,
// round-to-nearest-even, flush-to-zero denormals and IEEE-style status flags.
module fp_multiplier_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1+EXP_W+MAN_W-1:0]   a,
  input  logic [1+EXP_W+MAN_W-1:0]   b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1+EXP_W+MAN_W-1:0]   out_data,
  output logic [3:0]                 out_flags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EZERO = '0;

  typedef enum logic [1:0] {K_NORM, K_ZERO, K_INF, K_NAN} kind_t;

  function automatic kind_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0)                 return K_ZERO;
    else if (e == '1 && f == '0) return K_INF;
    else if (e == '1)            return K_NAN;
    else                         return K_NORM;
  endfunction

  // Returns {carry, frac}; carry set means the rounded mantissa reached 2.0
  function automatic logic [MAN_W:0] round_rne(input logic [MAN_W-1:0] frac,
                                               input logic guard, input logic sticky);
    return {1'b0, frac} + {{MAN_W{1'b0}}, guard & (sticky | frac[0])};
  endfunction

  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  kind_t ka, kb, kind_s1;
  logic  inv_s1;
  always_comb begin
    ka = classify(a[W-2:MAN_W], a[MAN_W-1:0]);
    kb = classify(b[W-2:MAN_W], b[MAN_W-1:0]);
    inv_s1  = 1'b0;
    kind_s1 = K_NORM;
    if (ka == K_NAN || kb == K_NAN) begin
      kind_s1 = K_NAN;
    end else if ((ka == K_INF && kb == K_ZERO) || (ka == K_ZERO && kb == K_INF)) begin
      kind_s1 = K_NAN;
      inv_s1  = 1'b1;
    end else if (ka == K_INF || kb == K_INF) begin
      kind_s1 = K_INF;
    end else if (ka == K_ZERO || kb == K_ZERO) begin
      kind_s1 = K_ZERO;
    end
  end

  logic                    vld_p0, vld_p1;
  logic                    sign_p0, sign_p1;
  logic signed [EW-1:0]    exp_p0, exp_p1;
  kind_t                   kind_p0, kind_p1;
  logic                    inv_p0, inv_p1;
  logic [MAN_W:0]          man_a_p0, man_b_p0;
  logic [PW-1:0]           prod_p1;
  logic [W-1:0]            res_s3;
  logic [3:0]              flags_s3;

  // Stage 1: unpack, classify, sign and biased exponent sum
  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p0  <= a[W-1] ^ b[W-1];
      exp_p0   <= $signed({2'b00, a[W-2:MAN_W]}) + $signed({2'b00, b[W-2:MAN_W]}) - BIAS;
      kind_p0  <= kind_s1;
      inv_p0   <= inv_s1;
      man_a_p0 <= {1'b1, a[MAN_W-1:0]};
      man_b_p0 <= {1'b1, b[MAN_W-1:0]};
    end
  end

  // Stage 2: mantissa product
  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p1 <= sign_p0;
      exp_p1  <= exp_p0;
      kind_p1 <= kind_p0;
      inv_p1  <= inv_p0;
      prod_p1 <= PW'(man_a_p0) * PW'(man_b_p0);
    end
  end

  // Stage 3: normalise, round, pack, flags
  logic [PW-2:0]        norm;
  logic                 guard, sticky;
  logic [MAN_W:0]       rnd;
  logic signed [EW-1:0] e_n, e_r;
  always_comb begin
    norm   = prod_p1[PW-1] ? prod_p1[PW-2:0] : {prod_p1[PW-3:0], 1'b0};
    guard  = norm[MAN_W];
    sticky = |norm[MAN_W-1:0];
    rnd    = round_rne(norm[PW-2:MAN_W+1], guard, sticky);
    e_n    = exp_p1 + $signed({{(EW-1){1'b0}}, prod_p1[PW-1]});
    e_r    = e_n + $signed({{(EW-1){1'b0}}, rnd[MAN_W]});
    res_s3   = '0;
    flags_s3 = '0;
    case (kind_p1)
      K_NAN: begin
        res_s3   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        flags_s3 = {inv_p1, 3'b000};
      end
      K_INF:  res_s3 = {sign_p1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      K_ZERO: res_s3 = {sign_p1, {(W-1){1'b0}}};
      default: begin
        if (e_r >= EMAX) begin
          res_s3   = {sign_p1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_s3 = 4'b0101;
        end else if (e_r <= EZERO) begin
          res_s3   = {sign_p1, {(W-1){1'b0}}};
          flags_s3 = 4'b0011;
        end else begin
          res_s3   = {sign_p1, e_r[EXP_W-1:0], rnd[MAN_W-1:0]};
          flags_s3 = {3'b000, guard | sticky};
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (adv) begin
      vld_p0    <= in_valid;
      vld_p1    <= vld_p0;
      out_valid <= vld_p1;
      out_data  <= res_s3;
      out_flags <= flags_s3;
    end
  end
endmodule
